// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NUM_STAGES downstream reset domains in order,
// STAGE_DELAY cycles apart, once the MSS reports ready. A soft-reset
// request pulls every domain back into reset and restarts the sequence.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16
) (
  input  logic                  clk_i,
  input  logic                  fabric_reset_n_i,
  input  logic                  mss_ready_i,
  input  logic                  force_rst_i,
  output logic [NUM_STAGES-1:0] stage_rst_n_o,
  output logic                  seq_done_o
);

  localparam int CNT_W = $clog2(STAGE_DELAY);
  localparam int IDX_W = $clog2(NUM_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SEQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stg_q, stg_d;
  logic                    done_q, done_d;
  logic [1:0]              rdy_sync_q, frc_sync_q;
  logic                    rdy_s, frc_s;

  // Two-flop synchronisers for the asynchronous MSS level and soft reset.
  always_ff @(posedge clk_i or negedge fabric_reset_n_i) begin
    if (!fabric_reset_n_i) begin
      rdy_sync_q <= 2'b00;
      frc_sync_q <= 2'b00;
    end else begin
      rdy_sync_q <= {rdy_sync_q[0], mss_ready_i};
      frc_sync_q <= {frc_sync_q[0], force_rst_i};
    end
  end

  assign rdy_s = rdy_sync_q[1];
  assign frc_s = frc_sync_q[1];

  // State, delay counter, stage index and registered outputs.
  always_ff @(posedge clk_i or negedge fabric_reset_n_i) begin
    if (!fabric_reset_n_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stg_q   <= stg_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. The soft reset wins over any release due this edge;
  // the counter saturates so a late MSS_READY releases stage 0 immediately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stg_d   = stg_q;
    done_d  = done_q;
    if (frc_s) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      stg_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (rdy_s) begin
            stg_d[0] = 1'b1;
            cnt_d    = '0;
            idx_d    = IDX_W'(1);
            if (NUM_STAGES == 1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = SEQ;
            end
          end
        end
        SEQ: begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (idx_q == IDX_W'(i)) stg_d[i] = 1'b1;
            end
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  assign stage_rst_n_o = stg_q;
  assign seq_done_o    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. The reference tracks only two facts: the edge
// at which the release countdown last started, and the edge at which stage 0
// was released; the released-stage count follows arithmetically from those.
module tb_reset_sequencer;
  localparam int NS = 4;
  localparam int SD = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          mss   = 1'b0;
  logic          frc   = 1'b0;
  logic [NS-1:0] stg;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  int e;        // edge number since reset release
  int start;    // edge at which the delay count last restarted
  int rel0;     // edge at which stage 0 was released, -1 if not yet
  bit m1, m2, f1, f2;  // input samples from the previous two edges

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_STAGES(NS), .STAGE_DELAY(SD)) dut (
    .clk_i            (clk),
    .fabric_reset_n_i (rst_n),
    .mss_ready_i      (mss),
    .force_rst_i      (frc),
    .stage_rst_n_o    (stg),
    .seq_done_o       (done)
  );

  function automatic int released();
    int k;
    if (rel0 < 0) return 0;
    k = 1 + (e - rel0) / SD;
    return (k > NS) ? NS : k;
  endfunction

  function automatic logic [NS-1:0] exp_vec();
    logic [NS-1:0] v;
    int n;
    v = '0;
    n = released();
    for (int i = 0; i < NS; i++) if (i < n) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_done();
    return released() == NS;
  endfunction

  task automatic model_reset();
    e = 0; start = 0; rel0 = -1;
    m1 = 0; m2 = 0; f1 = 0; f2 = 0;
  endtask

  task automatic check(input string name, input logic [NS-1:0] es, input logic ed);
    n_cmp++;
    if (stg !== es || done !== ed) begin
      n_bad++;
      $display("FAIL %s edge %0d: got stage=%b done=%b, want stage=%b done=%b",
               name, e, stg, done, es, ed);
    end
  endtask

  // One clock: advance the reference on the rising edge, compare on the falling edge.
  task automatic step();
    bit rdy, fr;
    @(posedge clk);
    if (rst_n) begin
      e++;
      rdy = m2; fr = f2;
      m2 = m1; m1 = mss;
      f2 = f1; f1 = frc;
      if (fr) begin
        start = e;
        rel0  = -1;
      end else if (rel0 < 0 && rdy && (e - start) >= SD) begin
        rel0 = e;
      end
    end
    @(negedge clk);
    check("cycle", exp_vec(), exp_done());
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  // Hand-computed expectation: pins the reference and the DUT.
  task automatic lit(input string name, input logic [NS-1:0] es, input logic ed);
    n_cmp++;
    if (exp_vec() !== es || exp_done() !== ed) begin
      n_bad++;
      $display("FAIL model_%s edge %0d: model stage=%b done=%b, want stage=%b done=%b",
               name, e, exp_vec(), exp_done(), es, ed);
    end
    check(name, es, ed);
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1 check("async_rst", '0, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // Short reset pulse well clear of the next rising edge.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 check("async_pulse", '0, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Ready throughout: releases at 16/32/48/64
    mss = 1'b1; frc = 1'b0;
    do_reset();
    run_to(15); lit("pre_s0", 4'b0000, 1'b0);
    step();     lit("s0",     4'b0001, 1'b0);
    run_to(32); lit("s1",     4'b0011, 1'b0);
    run_to(48); lit("s2",     4'b0111, 1'b0);
    run_to(63); lit("pre_s3", 4'b0111, 1'b0);
    step();     lit("s3",     4'b1111, 1'b1);

    // Soft reset from DONE: sampled high at 70, low at 80
    run_to(69); frc = 1'b1;
    step();
    step();     lit("frc_n1",  4'b1111, 1'b1);
    step();     lit("frc_n2",  4'b0000, 1'b0);
    run_to(79); frc = 1'b0;
    run_to(96); lit("frc_m16", 4'b0000, 1'b0);
    step();     lit("frc_m17", 4'b0001, 1'b0);

    // Fabric reset pulse between edges 40 and 41, timeline restarts
    do_reset();
    run_to(40); lit("pre_pulse", 4'b0011, 1'b0);
    pulse_reset();
    run_to(16); lit("pulse_s0", 4'b0001, 1'b0);
    run_to(64); lit("pulse_s3", 4'b1111, 1'b1);

    // Late ready: first sampled high at edge 100
    mss = 1'b0;
    do_reset();
    run_to(99);  mss = 1'b1;
    run_to(101); lit("late_101", 4'b0000, 1'b0);
    step();      lit("late_102", 4'b0001, 1'b0);
    run_to(149); lit("late_149", 4'b0111, 1'b0);
    step();      lit("late_150", 4'b1111, 1'b1);

    // Soft reset sampled at 14 suppresses the release at 16
    mss = 1'b1;
    do_reset();
    run_to(13); frc = 1'b1;
    step();     frc = 1'b0;
    run_to(16); lit("frc14_16", 4'b0000, 1'b0);
    run_to(31); lit("frc14_31", 4'b0000, 1'b0);
    step();     lit("frc14_32", 4'b0001, 1'b0);

    // Ready dropped after stage 0: later stages still released
    do_reset();
    run_to(16); lit("drop_s0", 4'b0001, 1'b0);
    mss = 1'b0;
    run_to(64); lit("drop_s3", 4'b1111, 1'b1);

    // Randomised ready / soft-reset activity, occasional reset pulses
    for (int r = 0; r < 8; r++) begin
      mss = 1'($urandom_range(0, 1));
      frc = 1'b0;
      do_reset();
      for (int i = 0; i < 500; i++) begin
        step();
        if ($urandom_range(0, 19) == 0) mss = ~mss;
        if (frc) begin
          if ($urandom_range(0, 7) == 0) frc = 1'b0;
        end else if ($urandom_range(0, 99) == 0) begin
          frc = 1'b1;
        end
        if ($urandom_range(0, 299) == 0) pulse_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of downstream reset domains released in order; legal range 1..8.
REQ-002 Parameter STAGE_DELAY, default 16, clock cycles between consecutive stage releases; legal range 2..65535.
REQ-003 CLK  input  1  single clock; all state in this block is clocked on its rising edge.
REQ-004 FABRIC_RESET_N  input  1  reset, asynchronous, active-low; deassertion arrives already synchronised to CLK by the upstream reset stage.
REQ-005 MSS_READY  input  1  asynchronous level from the MSS; high means the processor subsystem accepts fabric traffic.
REQ-006 FORCE_RST  input  1  asynchronous level soft-reset request; high holds all domains in reset.
REQ-007 STAGE_RST_N  output  NUM_STAGES  per-domain active-low reset; bit 0 is released first and bit NUM_STAGES-1 last.
REQ-008 SEQ_DONE  output  1  high when every domain is out of reset.

Function
REQ-009 MSS_READY and FORCE_RST shall each pass through a dedicated 2-flop synchroniser reset to 0; the FSM uses only the second-flop outputs (rdy_s, frc_s).
REQ-010 The FSM shall have exactly three states: HOLD (counting, no stage released yet), SEQ (releasing stages), DONE (all released).
REQ-011 A down-counter is not used; a single up-counter cnt of width clog2(STAGE_DELAY) and a stage index idx of width clog2(NUM_STAGES+1) shall be used.
REQ-012 In HOLD and SEQ, while frc_s=0, cnt shall increment by 1 per cycle until it equals STAGE_DELAY-1.
REQ-013 cnt shall saturate at STAGE_DELAY-1 and never wrap.
REQ-014 HOLD -> SEQ: on the edge where cnt==STAGE_DELAY-1 and rdy_s=1, STAGE_RST_N[0] shall go 1, cnt shall clear to 0, and idx shall become 1.
REQ-015 If cnt==STAGE_DELAY-1 and rdy_s=0 in HOLD, the FSM shall wait in HOLD with cnt saturated and shall release stage 0 on the first edge at which rdy_s=1.
REQ-016 In SEQ, on each edge with cnt==STAGE_DELAY-1, STAGE_RST_N[idx] shall go 1, cnt shall clear, and idx shall increment; MSS_READY does not gate stages 1 and above.
REQ-017 The edge that releases stage NUM_STAGES-1 shall also set SEQ_DONE=1 and move the FSM to DONE; with NUM_STAGES=1 this occurs on the HOLD -> SEQ edge, and the FSM goes directly to DONE.
REQ-018 Released stages shall remain released (monotonic) until FORCE_RST or reset.
REQ-019 Deassertion of MSS_READY after stage 0 is released shall have no effect.
REQ-020 frc_s=1 in any state shall, on the next edge, drive all STAGE_RST_N bits and SEQ_DONE to 0, clear cnt and idx, and enter HOLD.
REQ-021 While frc_s=1, the FSM shall stay in HOLD with cnt held at 0.
REQ-022 When frc_s returns to 0, the sequence shall restart exactly as after power-on reset.
REQ-023 frc_s=1 shall take priority over any stage release due on the same edge.
REQ-024 All outputs shall be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-025 FABRIC_RESET_N=0 shall asynchronously force STAGE_RST_N to all zeros, SEQ_DONE=0, FSM=HOLD, cnt=0, idx=0, and both synchroniser chains to 0.
REQ-026 Reset asserted mid-sequence or in DONE shall abort immediately with the values in REQ-025.
REQ-027 After reset release, the block shall behave identically to first power-up.

Verification (defaults NUM_STAGES=4, STAGE_DELAY=16; edge 1 = first rising CLK edge after FABRIC_RESET_N rises)
REQ-028 MSS_READY=1 and FORCE_RST=0 throughout -> STAGE_RST_N becomes 0001 at edge 16, 0011 at edge 32, 0111 at edge 48, and 1111 with SEQ_DONE=1 at edge 64.
REQ-029 MSS_READY=0 until it is first sampled high at edge 100 -> STAGE_RST_N stays 0000 until edge 102, becomes 0001 at edge 102, and SEQ_DONE=1 at edge 150.
REQ-030 In DONE, FORCE_RST sampled high at edge N -> STAGE_RST_N=0000 and SEQ_DONE=0 at edge N+2; FORCE_RST sampled low at edge M -> 0001 at edge M+17.
REQ-031 FABRIC_RESET_N pulsed low between edges 40 and 41 -> outputs go to 0000 asynchronously without waiting for a clock edge; after release, the REQ-028 timeline repeats from the new edge 1.
REQ-032 FORCE_RST sampled high at edge 14 -> no release at edge 16 and outputs stay 0000; also, MSS_READY toggled low after edge 16 -> no effect on later releases.
